// File: rtl/mips32_mem_responder.sv
// Word-addressed LW/SW data-memory responder with req/ack handshake and programmable wait states.
// Optional access counters (rd_count/wr_count) are enabled by defining MEMRSP_STATS_EN.
module mips32_mem_responder #(
  parameter int DEPTH       = 1024,
  parameter int ADDR_W      = 10,
  parameter int WAIT_STATES = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  output logic              busy,
  output logic              ack,
  output logic [31:0]       rdata,
  output logic              err
`ifdef MEMRSP_STATS_EN
  ,
  output logic [15:0]       rd_count,
  output logic [15:0]       wr_count
`endif
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_WAIT   = 2'd1;
  localparam logic [1:0] ST_ACCESS = 2'd2;

  localparam logic [3:0]  WAIT_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;
  localparam logic [31:0] DEPTH_LIM = 32'(DEPTH);

  logic [1:0]        state_r;
  logic [1:0]        state_nxt_s;
  logic [3:0]        wait_cnt_r;
  logic              we_r;
  logic [ADDR_W-1:0] addr_r;
  logic [31:0]       wdata_r;
  logic              in_range_s;
  logic              do_access_s;

  logic [31:0] mem [DEPTH];

  // Address range check and qualified access strobe for the latched request
  always_comb begin
    in_range_s  = (32'(addr_r) < DEPTH_LIM);
    do_access_s = (state_r == ST_ACCESS) && in_range_s;
  end

  // Next-state decode
  always_comb begin
    state_nxt_s = ST_IDLE;
    case (state_r)
      ST_IDLE: begin
        if (req) begin
          state_nxt_s = (WAIT_STATES > 0) ? ST_WAIT : ST_ACCESS;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_WAIT: begin
        if (wait_cnt_r == 4'd0) begin
          state_nxt_s = ST_ACCESS;
        end else begin
          state_nxt_s = ST_WAIT;
        end
      end
      ST_ACCESS: state_nxt_s = ST_IDLE;
      default:   state_nxt_s = ST_IDLE;
    endcase
  end

  // Control state, request latch and registered handshake outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= ST_IDLE;
      wait_cnt_r <= 4'd0;
      we_r       <= 1'b0;
      addr_r     <= '0;
      wdata_r    <= 32'd0;
      busy       <= 1'b0;
      ack        <= 1'b0;
      err        <= 1'b0;
      rdata      <= 32'd0;
    end else begin
      state_r <= state_nxt_s;
      case (state_r)
        ST_IDLE: begin
          ack <= 1'b0;
          err <= 1'b0;
          if (req) begin
            we_r       <= we;
            addr_r     <= addr;
            wdata_r    <= wdata;
            busy       <= 1'b1;
            wait_cnt_r <= WAIT_LOAD;
          end else begin
            busy <= 1'b0;
          end
        end
        ST_WAIT: begin
          ack <= 1'b0;
          err <= 1'b0;
          if (wait_cnt_r != 4'd0) begin
            wait_cnt_r <= wait_cnt_r - 4'd1;
          end
        end
        ST_ACCESS: begin
          ack  <= 1'b1;
          busy <= 1'b0;
          err  <= !in_range_s;
          // Out-of-range accesses leave rdata holding its previous value
          if (in_range_s && !we_r) begin
            rdata <= mem[addr_r];
          end
        end
        default: begin
          ack  <= 1'b0;
          err  <= 1'b0;
          busy <= 1'b0;
        end
      endcase
    end
  end

  // Data store write port; contents are deliberately not reset
  always_ff @(posedge clk) begin
    if (do_access_s && we_r) begin
      mem[addr_r] <= wdata_r;
    end
  end

`ifdef MEMRSP_STATS_EN
  // Saturating counters of successful reads and writes
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_count <= 16'd0;
      wr_count <= 16'd0;
    end else if (do_access_s) begin
      if (we_r) begin
        if (wr_count != 16'hFFFF) begin
          wr_count <= wr_count + 16'd1;
        end
      end else begin
        if (rd_count != 16'hFFFF) begin
          rd_count <= rd_count + 16'd1;
        end
      end
    end
  end
`endif

endmodule
